// File: rtl/div_unit_if.sv
// Request/response handshake between the EX stage and the iterative divider.
interface div_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic [1:0]      Op;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] Q;
    logic            DivZero;

    modport master (
        output in_valid, A, B, Op, out_ready,
        input  in_ready, out_valid, Q, DivZero
    );

    modport slave (
        input  in_valid, A, B, Op, out_ready,
        output in_ready, out_valid, Q, DivZero
    );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     flush,
    div_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN:0]   rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic            op_rem_q, op_rem_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic [XLEN-1:0] res_q, res_d;
    logic            dz_q, dz_d;

    logic [XLEN+1:0] rem_sh, diff;
    logic [XLEN:0]   rem_step;
    logic [XLEN-1:0] quo_step, fix_quo, fix_rem, abs_a, abs_b;
    logic            sign_a, sign_b, take;

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path leaves it unassigned and infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        op_rem_d  = op_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        res_d     = res_q;
        dz_d      = dz_q;

        // One restoring step; the borrow out of the wide difference decides the quotient bit.
        rem_sh   = {rem_q, quo_q[XLEN-1]};
        diff     = rem_sh - {2'b00, dvs_q};
        take     = ~diff[XLEN+1];
        rem_step = take ? diff[XLEN:0] : rem_sh[XLEN:0];
        quo_step = {quo_q[XLEN-2:0], take};
        fix_quo  = neg_quo_q ? -quo_step : quo_step;
        fix_rem  = neg_rem_q ? -rem_step[XLEN-1:0] : rem_step[XLEN-1:0];

        sign_a = ~bus.Op[0] & bus.A[XLEN-1];
        sign_b = ~bus.Op[0] & bus.B[XLEN-1];
        abs_a  = sign_a ? -bus.A : bus.A;
        abs_b  = sign_b ? -bus.B : bus.B;

        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    op_rem_d  = bus.Op[1];
                    neg_quo_d = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    rem_d     = '0;
                    quo_d     = abs_a;
                    dvs_d     = abs_b;
                    cnt_d     = '0;
                    if (bus.B == '0) begin
                        res_d   = bus.Op[1] ? bus.A : '1;
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                    end else if (!bus.Op[0] && bus.A == {1'b1, {(XLEN-1){1'b0}}} && bus.B == '1) begin
                        res_d   = bus.Op[1] ? '0 : bus.A;
                        dz_d    = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(XLEN-1)) begin
                    res_d   = op_rem_q ? fix_rem : fix_quo;
                    dz_d    = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A flush drops whatever was in flight and leaves the visible result untouched.
        if (flush) begin
            state_d = S_IDLE;
            res_d   = res_q;
            dz_d    = dz_q;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            op_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            res_q     <= '0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            op_rem_q  <= op_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            res_q     <= res_d;
            dz_q      <= dz_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.Q         = res_q;
    assign bus.DivZero   = dz_q;
endmodule
